// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares one single-ported memory between a CPU and a video scanout reader.
// The CPU normally wins contention. After STARVE_MAX consecutive cycles in
// which video was requesting but denied, video is granted for exactly one
// cycle. Read data is returned one cycle after the grant on a per-requester
// registered response.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata       CPU request (15-bit word address, 16-bit data)
//   cpu_gnt                     combinational grant, access happens this cycle
//   cpu_rvalid/cpu_rdata        registered read response (1-cycle latency)
//   vid_req/vid_addr            video read request, 13-bit screen word offset
//   vid_gnt                     combinational grant
//   vid_rvalid/vid_rdata        registered read response (1-cycle latency)
//   mem_load/address/in         shared memory port (write enable, addr, data)
//   mem_out                     combinational memory read data for mem_address
module memory_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic        vid_gnt,
  output logic        vid_rvalid,
  output logic [15:0] vid_rdata,
  output logic        mem_load,
  output logic [14:0] mem_address,
  output logic [15:0] mem_in,
  input  logic [15:0] mem_out
);

  typedef enum logic {
    CPU_PRIO  = 1'b0,
    VID_FORCE = 1'b1
  } state_e;

  localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];
  // Addresses at and above this belong to the keyboard or are unmapped.
  localparam logic [14:0] KBD_BASE = 15'h6000;

  state_e      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d;
  logic        vid_rvalid_q, vid_rvalid_d;
  logic [15:0] vid_rdata_q, vid_rdata_d;

  // Grant decision; grants are forced low while reset is asserted.
  always_comb begin
    cpu_gnt = 1'b0;
    vid_gnt = 1'b0;
    if (!rst_n) begin
      cpu_gnt = 1'b0;
      vid_gnt = 1'b0;
    end else begin
      case (state_q)
        CPU_PRIO: begin
          cpu_gnt = cpu_req;
          vid_gnt = vid_req & ~cpu_req;
        end
        VID_FORCE: begin
          vid_gnt = vid_req;
          cpu_gnt = cpu_req & ~vid_req;
        end
        default: begin
          cpu_gnt = 1'b0;
          vid_gnt = 1'b0;
        end
      endcase
    end
  end

  // Next-state and starvation counter. The counter is cleared on entry to
  // VID_FORCE so it is already zero when CPU_PRIO is re-entered.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      CPU_PRIO: begin
        if (vid_req && !vid_gnt) begin
          if ((starve_cnt_q + 4'd1) == STARVE_LIM) begin
            state_d      = VID_FORCE;
            starve_cnt_d = 4'd0;
          end else begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else begin
          starve_cnt_d = 4'd0;
        end
      end
      VID_FORCE: begin
        state_d      = CPU_PRIO;
        starve_cnt_d = 4'd0;
      end
      default: begin
        state_d      = CPU_PRIO;
        starve_cnt_d = 4'd0;
      end
    endcase
  end

  // Shared memory port mux; writes to keyboard/unmapped space are dropped.
  always_comb begin
    mem_load    = 1'b0;
    mem_address = 15'd0;
    mem_in      = 16'd0;
    if (cpu_gnt) begin
      mem_address = cpu_addr;
      mem_in      = cpu_wdata;
      mem_load    = cpu_we & (cpu_addr < KBD_BASE);
    end else if (vid_gnt) begin
      mem_address = {2'b10, vid_addr};
      mem_load    = 1'b0;
      mem_in      = 16'd0;
    end else begin
      mem_load    = 1'b0;
      mem_address = 15'd0;
      mem_in      = 16'd0;
    end
  end

  // Read responses: capture mem_out on a granted read, otherwise hold rdata.
  always_comb begin
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    vid_rvalid_d = vid_gnt;
    if (cpu_rvalid_d) begin
      cpu_rdata_d = mem_out;
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
    if (vid_rvalid_d) begin
      vid_rdata_d = mem_out;
    end else begin
      vid_rdata_d = vid_rdata_q;
    end
  end

  // State, counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CPU_PRIO;
      starve_cnt_q <= 4'd0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= 16'd0;
      vid_rvalid_q <= 1'b0;
      vid_rdata_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vid_rvalid_q <= vid_rvalid_d;
      vid_rdata_q  <= vid_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign vid_rvalid = vid_rvalid_q;
  assign vid_rdata  = vid_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter
// Directed scenarios followed by constrained-random traffic, compared every
// cycle against a behavioural model of the arbitration rules and memory.
module tb_memory_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_gnt, vid_rvalid;
  logic [15:0] vid_rdata;
  logic        mem_load;
  logic [14:0] mem_address;
  logic [15:0] mem_in;
  logic [15:0] mem_out;
  logic [15:0] kb_val;

  int n_checks = 0;
  int n_pass   = 0;

  // memory seen by the DUT
  bit   [15:0] mem_dat [0:32767];
  bit          mem_wr  [0:32767];
  // reference memory maintained by the model
  bit   [15:0] ref_dat [0:32767];
  bit          ref_wr  [0:32767];

  // reference model state
  int          streak;
  bit          force_nxt;
  logic        exp_crv, exp_vrv;
  logic [15:0] exp_crd, exp_vrd;
  bit          cpu_denied, vid_denied;
  logic        obs_vgnt, obs_mload, obs_vrv;

  memory_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_load(mem_load), .mem_address(mem_address), .mem_in(mem_in),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_pat(input logic [14:0] a);
    return {a[7:0], a[14:7]} ^ 16'hC3A5;
  endfunction

  always_comb begin
    if (mem_address == 15'h6000) mem_out = kb_val;
    else if (mem_wr[mem_address]) mem_out = mem_dat[mem_address];
    else mem_out = init_pat(mem_address);
  end

  always_ff @(posedge clk) begin
    if (mem_load) begin
      mem_dat[mem_address] <= mem_in;
      mem_wr[mem_address]  <= 1'b1;
    end
  end

  function automatic logic [15:0] ref_read(input logic [14:0] a);
    if (a == 15'h6000) return kb_val;
    if (ref_wr[a]) return ref_dat[a];
    return init_pat(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic ref_reset();
    streak    = 0;
    force_nxt = 1'b0;
    exp_crv   = 1'b0;
    exp_vrv   = 1'b0;
    exp_crd   = 16'd0;
    exp_vrd   = 16'd0;
    cpu_denied = 1'b0;
    vid_denied = 1'b0;
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [14:0] a, input logic [15:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_vid(input logic r, input logic [12:0] a);
    vid_req = r; vid_addr = a;
  endtask

  // One clock cycle: check combinational outputs mid-cycle against the model,
  // advance the model, then check the registered responses after the edge.
  task automatic cycle();
    logic        eg_c, eg_v, el;
    logic [14:0] ea;
    logic [15:0] ei;
    @(negedge clk);
    if (force_nxt) begin
      eg_v = vid_req;
      eg_c = cpu_req && !vid_req;
    end else begin
      eg_c = cpu_req;
      eg_v = vid_req && !cpu_req;
    end
    ea = 15'd0; ei = 16'd0; el = 1'b0;
    if (eg_c) begin
      ea = cpu_addr;
      ei = cpu_wdata;
      el = cpu_we && (cpu_addr < 15'h6000);
    end else if (eg_v) begin
      ea = 15'h4000 + 15'(vid_addr);
    end
    chk("cpu_gnt", 32'(cpu_gnt), 32'(eg_c));
    chk("vid_gnt", 32'(vid_gnt), 32'(eg_v));
    chk("mem_load", 32'(mem_load), 32'(el));
    chk("mem_address", 32'(mem_address), 32'(ea));
    chk("mem_in", 32'(mem_in), 32'(ei));
    obs_vgnt  = vid_gnt;
    obs_mload = mem_load;

    exp_crv = eg_c && !cpu_we;
    if (exp_crv) exp_crd = ref_read(cpu_addr);
    exp_vrv = eg_v;
    if (exp_vrv) exp_vrd = ref_read(ea);
    if (el) begin
      ref_dat[ea] = ei;
      ref_wr[ea]  = 1'b1;
    end

    // one forced video cycle after STARVE_MAX denied video cycles in a row
    if (force_nxt) begin
      force_nxt = 1'b0;
      streak    = 0;
    end else if (vid_req && !eg_v) begin
      streak++;
      if (streak >= STARVE_MAX) begin
        force_nxt = 1'b1;
        streak    = 0;
      end
    end else begin
      streak = 0;
    end
    cpu_denied = cpu_req && !eg_c;
    vid_denied = vid_req && !eg_v;

    @(posedge clk);
    #1;
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_crv));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
    chk("vid_rvalid", 32'(vid_rvalid), 32'(exp_vrv));
    chk("vid_rdata", 32'(vid_rdata), 32'(exp_vrd));
    obs_vrv = vid_rvalid;
  endtask

  function automatic logic [14:0] rnd_addr();
    case ($urandom_range(0, 4))
      0:       return 15'($urandom_range(0, 15));
      1:       return 15'h4000 + 15'($urandom_range(0, 15));
      2:       return 15'h6000;
      3:       return 15'h6000 + 15'($urandom_range(1, 100));
      default: return 15'($urandom);
    endcase
  endfunction

  initial begin
    logic [9:0] pat;
    logic [4:0] rvp;
    logic [15:0] exp_last;

    ref_reset();
    kb_val = 16'h00A5;
    rst_n  = 1'b0;
    set_cpu(1'b1, 1'b1, 15'h0010, 16'h1111);
    set_vid(1'b1, 13'd1);
    #2;
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_vid_gnt", 32'(vid_gnt), 32'd0);
    chk("rst_mem_load", 32'(mem_load), 32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // CPU write then read back, first grant right after reset release
    set_cpu(1'b1, 1'b1, 15'h0010, 16'hBEEF);
    set_vid(1'b0, 13'd0);
    cycle();
    set_cpu(1'b1, 1'b0, 15'h0010, 16'h0000);
    cycle();
    chk("wr_rd_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("wr_rd_data", 32'(cpu_rdata), 32'h0000BEEF);
    set_cpu(1'b0, 1'b0, 15'h0000, 16'h0000);
    cycle();

    // sustained contention: 4 CPU cycles then 1 forced video cycle
    set_cpu(1'b1, 1'b0, 15'h0020, 16'h0000);
    set_vid(1'b1, 13'd5);
    pat = 10'd0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      pat = {pat[8:0], obs_vgnt};
    end
    chk("contention_pattern", 32'(pat), 32'(10'b0000100001));

    // video drops its request once: the starvation count restarts
    pat = 10'd0;
    for (int i = 0; i < 9; i++) begin
      set_vid((i == 3) ? 1'b0 : 1'b1, 13'd5);
      cycle();
      pat = {pat[8:0], obs_vgnt};
    end
    chk("starve_restart", 32'(pat), 32'(10'b0000000001));
    set_cpu(1'b0, 1'b0, 15'h0000, 16'h0000);
    set_vid(1'b0, 13'd0);
    cycle();

    // keyboard write is dropped, keyboard read returns its input
    set_cpu(1'b1, 1'b1, 15'h6000, 16'h1234);
    cycle();
    chk("kbd_wr_load", 32'(obs_mload), 32'd0);
    set_cpu(1'b1, 1'b0, 15'h6000, 16'h0000);
    cycle();
    chk("kbd_rd_data", 32'(cpu_rdata), 32'h000000A5);
    set_cpu(1'b0, 1'b0, 15'h0000, 16'h0000);

    // video-only streaming reads at full throughput
    rvp = 5'd0;
    for (int i = 0; i < 5; i++) begin
      set_vid((i < 4) ? 1'b1 : 1'b0, 13'(i));
      cycle();
      rvp = {rvp[3:0], obs_vrv};
    end
    chk("vid_stream_rvalid", 32'(rvp), 32'(5'b11110));
    exp_last = init_pat(15'h4003);
    chk("vid_stream_last", 32'(vid_rdata), 32'(exp_last));

    // reset asserted asynchronously while a CPU read is granted
    set_cpu(1'b1, 1'b0, 15'h0011, 16'h0000);
    set_vid(1'b1, 13'd7);
    @(negedge clk);
    chk("mid_gnt_before", 32'(cpu_gnt), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_gnt_during", 32'(cpu_gnt), 32'd0);
    chk("mid_load_during", 32'(mem_load), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("mid_rdata", 32'(cpu_rdata), 32'd0);
    #2;
    rst_n = 1'b1;
    ref_reset();
    #1;
    chk("post_rst_rvalid", 32'(cpu_rvalid), 32'd0);
    // contention after release: video forced after exactly 4 denials
    pat = 10'd0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      pat = {pat[8:0], obs_vgnt};
    end
    chk("post_rst_force", 32'(pat), 32'(10'b0000000001));

    // constrained-random traffic; denied requesters hold their request
    for (int i = 0; i < 1500; i++) begin
      if (!cpu_denied) begin
        set_cpu(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                rnd_addr(), 16'($urandom));
      end
      if (!vid_denied) begin
        set_vid(($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 15)) : 13'($urandom));
      end
      if ($urandom_range(0, 15) == 0) kb_val = 16'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
